// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier: one recoding step per clock, 2*WIDTH product on hi/lo.
// Define BOOTH_RADIX4_EN for radix-4 recoding (fewer steps, identical results).
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int E = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int PW     = 2*E + 2;
    localparam int NSTEPS = E / 2;
    localparam int PLSB   = 1;
`else
    localparam int PW     = 2*E + 1;
    localparam int NSTEPS = WIDTH + 1;
    localparam int PLSB   = 2;
`endif
    localparam int CW = $clog2(NSTEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [E-1:0]     a_q, a_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [PW-1:0]    p_step;
    logic [E-1:0]     a_ext;
    logic [E-1:0]     b_ext;

    always_comb begin
        if (signed_mode) begin
            a_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            b_ext = {{2{multiplier[WIDTH-1]}}, multiplier};
        end else begin
            a_ext = {2'b00, multiplicand};
            b_ext = {2'b00, multiplier};
        end
    end

`ifdef BOOTH_RADIX4_EN
    // Upper accumulator carries one guard bit so that +/-2A cannot overflow.
    logic [E:0] acc4;
    logic [E:0] a1;
    logic [E:0] a2;

    always_comb begin
        a1   = {a_q[E-1], a_q};
        a2   = {a_q, 1'b0};
        acc4 = p_q[PW-1:E+1];
        case (p_q[2:0])
            3'b001, 3'b010: acc4 = acc4 + a1;
            3'b011:         acc4 = acc4 + a2;
            3'b100:         acc4 = acc4 - a2;
            3'b101, 3'b110: acc4 = acc4 - a1;
            default:        acc4 = acc4;
        endcase
        p_step = {acc4[E], acc4[E], acc4, p_q[E:2]};
    end
`else
    logic [E-1:0] acc2;

    always_comb begin
        acc2 = p_q[PW-1:E+1];
        case (p_q[1:0])
            2'b01:   acc2 = acc2 + a_q;
            2'b10:   acc2 = acc2 - a_q;
            default: acc2 = acc2;
        endcase
        p_step = {acc2[E-1], acc2, p_q[E:1]};
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    a_d        = a_ext;
                    p_d        = '0;
                    p_d[E:1]   = b_ext;
                    cnt_d      = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                // The last step's result is taken straight from p_step so hi/lo land with done.
                if (cnt_q == CW'(NSTEPS - 1)) begin
                    state_d = S_DONE;
                    hi_d    = p_step[PLSB+2*WIDTH-1:PLSB+WIDTH];
                    lo_d    = p_step[PLSB+WIDTH-1:PLSB];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
